vec_arb_mux: RTL and testbench

Parametrised N-requestor arbiter that merges per-requestor valid/ready request channels onto one registered memory-side channel. Successor to the fixed four-way valid-selected mux: it adds real handshaking, a one-entry output register, a reported grant index and an optional round-robin mode. It sits between the requestor vector and the memory port.

---
 rtl/vec_arb_pkg.sv | 13 +
 rtl/vec_arb_pick.sv | 35 +++
 rtl/vec_arb_mux.sv | 84 ++++++++
 tb/tb_vec_arb_mux.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/vec_arb_pkg.sv
// Shared types and helpers for the vec_arb_mux requestor arbiter.
package vec_arb_pkg;

  localparam int unsigned REQ_IDX_MAX_W = 16;

  // Wide enough for any supported requestor count; narrowed to IW at use.
  typedef logic [REQ_IDX_MAX_W-1:0] req_idx_t;

  function automatic int unsigned idx_w(input int unsigned n);
    return $clog2(n);
  endfunction

endpackage

// File: rtl/vec_arb_pick.sv
// Combinational grant picker: first valid index starting at `start`,
// scanning upward (round-robin) or downward (fixed priority) modulo N.
module vec_arb_pick
  import vec_arb_pkg::*;
#(
  parameter int unsigned N       = 4,
  parameter bit          DESCEND = 1'b1,
  localparam int unsigned IW     = idx_w(N)
) (
  input  logic [N-1:0]  valid,
  input  logic [IW-1:0] start,
  output logic [IW-1:0] grant,
  output logic          any
);

  req_idx_t    cand;
  int unsigned base;

  always_comb begin
    grant = '0;
    any   = 1'b0;
    cand  = '0;
    base  = 32'(start);
    for (int unsigned k = 0; k < N; k++) begin
      // Offsets are reduced modulo N, not 2^IW, so non-power-of-two N wraps correctly.
      if (DESCEND) cand = req_idx_t'((base + N - k) % N);
      else         cand = req_idx_t'((base + k) % N);
      if (!any && valid[cand[IW-1:0]]) begin
        any   = 1'b1;
        grant = cand[IW-1:0];
      end
    end
  end

endmodule

// File: rtl/vec_arb_mux.sv
// N-requestor valid/ready arbiter feeding a one-entry registered memory channel.
// Define VEC_ARB_RR_EN for round-robin arbitration; default is fixed priority (highest index).
module vec_arb_mux
  import vec_arb_pkg::*;
#(
  parameter int unsigned N  = 4,
  parameter int unsigned W  = 8,
  localparam int unsigned IW = idx_w(N)
) (
  input  logic           clk,
  input  logic           reset_n,
  input  logic [N-1:0]   io_requestor_req_valid,
  input  logic [N*W-1:0] io_requestor_req_bits,
  output logic [N-1:0]   io_requestor_req_ready,
  output logic           io_mem_valid,
  output logic [W-1:0]   io_mem_bits,
  output logic [IW-1:0]  io_mem_idx,
  input  logic           io_mem_ready
);

  logic          open;
  logic          any;
  logic          accept;
  logic [IW-1:0] grant;
  logic [IW-1:0] start;
  logic [W-1:0]  sel_bits;

`ifdef VEC_ARB_RR_EN
  localparam bit DESCEND = 1'b0;
  logic [IW-1:0] rr_ptr;

  // Search begins one past the last accepted index, wrapping at N-1.
  assign start = (rr_ptr == IW'(N - 1)) ? '0 : rr_ptr + 1'b1;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) rr_ptr <= IW'(N - 1);
    else if (accept) rr_ptr <= grant;
  end
`else
  localparam bit DESCEND = 1'b1;
  assign start = IW'(N - 1);
`endif

  vec_arb_pick #(
    .N       (N),
    .DESCEND (DESCEND)
  ) u_pick (
    .valid (io_requestor_req_valid),
    .start (start),
    .grant (grant),
    .any   (any)
  );

  assign open   = !io_mem_valid || io_mem_ready;
  assign accept = open && any;

  always_comb begin
    sel_bits = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (grant == IW'(i)) sel_bits = io_requestor_req_bits[i*W +: W];
    end
  end

  always_comb begin
    io_requestor_req_ready = '0;
    if (accept) io_requestor_req_ready[grant] = 1'b1;
  end

  // A same-cycle accept overrides the drain, keeping valid high for full throughput.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      io_mem_valid <= 1'b0;
      io_mem_bits  <= '0;
      io_mem_idx   <= '0;
    end else if (accept) begin
      io_mem_valid <= 1'b1;
      io_mem_bits  <= sel_bits;
      io_mem_idx   <= grant;
    end else if (io_mem_ready) begin
      io_mem_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_vec_arb_mux.sv
// Self-checking bench for vec_arb_mux: vector table, directed corner cases and a random run
// against a behavioural model. Expectations follow VEC_ARB_RR_EN when defined.
module tb_vec_arb_mux;

  localparam int unsigned N = 4;
  localparam int unsigned W = 8;
  localparam logic [N*W-1:0] PAY = 32'h13121110;

  logic           clk = 1'b0;
  logic           reset_n;
  logic [N-1:0]   req_valid;
  logic [N*W-1:0] req_bits;
  logic [N-1:0]   req_ready;
  logic           mem_valid;
  logic [W-1:0]   mem_bits;
  logic [1:0]     mem_idx;
  logic           mem_ready;

  int total = 0;
  int bad   = 0;

  logic        m_valid;
  logic [W-1:0] m_bits;
  int unsigned m_idx;
  int unsigned m_ptr;

  typedef struct {
    logic [N-1:0] v;
    logic         mr;
    logic [N-1:0] rdy;
    logic         mv;
    logic [W-1:0] mb;
    logic [1:0]   mi;
  } vec_t;

  vec_t tbl [8];

  vec_arb_mux #(.N(N), .W(W)) dut (
    .clk                    (clk),
    .reset_n                (reset_n),
    .io_requestor_req_valid (req_valid),
    .io_requestor_req_bits  (req_bits),
    .io_requestor_req_ready (req_ready),
    .io_mem_valid           (mem_valid),
    .io_mem_bits            (mem_bits),
    .io_mem_idx             (mem_idx),
    .io_mem_ready           (mem_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_valid = 1'b0;
    m_bits  = '0;
    m_idx   = 0;
    m_ptr   = N - 1;
  endtask

  // Returns the granted index, or -1 when nothing is valid.
  function automatic int model_grant(input logic [N-1:0] v);
    int vi;
    int best;
    int g;
    vi   = int'(v);
    g    = -1;
    best = N;
    if (vi == 0) return -1;
`ifdef VEC_ARB_RR_EN
    for (int i = 0; i < N; i++) begin
      if (v[i] && ((i + N - int'(m_ptr) - 1) % N) < best) begin
        best = (i + N - int'(m_ptr) - 1) % N;
        g    = i;
      end
    end
`else
    g = $clog2(vi + 1) - 1;
`endif
    return g;
  endfunction

  // Entered at posedge+1; returns at the following posedge+1 with outputs checked.
  task automatic run_cycle(input logic [N-1:0] v, input logic [N*W-1:0] b, input logic mr,
                           output logic [N-1:0] rdy);
    int           g;
    bit           open;
    logic [N-1:0] exp_rdy;
    req_valid = v;
    req_bits  = b;
    mem_ready = mr;
    #1;
    open    = !m_valid || mr;
    g       = model_grant(v);
    exp_rdy = '0;
    if (open && g >= 0) exp_rdy[g] = 1'b1;
    rdy = req_ready;
    chk("ready", 32'(req_ready), 32'(exp_rdy));
    @(posedge clk);
    #1;
    if (open && g >= 0) begin
      m_valid = 1'b1;
      m_bits  = b[g*W +: W];
      m_idx   = g;
      m_ptr   = g;
    end else if (mr) begin
      m_valid = 1'b0;
    end
    chk("mem_valid", 32'(mem_valid), 32'(m_valid));
    chk("mem_bits", 32'(mem_bits), 32'(m_bits));
    chk("mem_idx", 32'(mem_idx), m_idx);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [N-1:0]   r;
    logic [N*W-1:0] b;
    int             exp_i;

`ifdef VEC_ARB_RR_EN
    tbl[0] = '{4'b1011, 1'b1, 4'b0001, 1'b1, 8'h10, 2'd0};
    tbl[1] = '{4'b0011, 1'b0, 4'b0000, 1'b1, 8'h10, 2'd0};
`else
    tbl[0] = '{4'b1011, 1'b1, 4'b1000, 1'b1, 8'h13, 2'd3};
    tbl[1] = '{4'b0011, 1'b0, 4'b0000, 1'b1, 8'h13, 2'd3};
`endif
    tbl[2] = '{4'b0011, 1'b1, 4'b0010, 1'b1, 8'h11, 2'd1};
    tbl[3] = '{4'b0000, 1'b1, 4'b0000, 1'b0, 8'h11, 2'd1};
    tbl[4] = '{4'b0101, 1'b0, 4'b0100, 1'b1, 8'h12, 2'd2};
    tbl[5] = '{4'b0001, 1'b0, 4'b0000, 1'b1, 8'h12, 2'd2};
    tbl[6] = '{4'b0001, 1'b1, 4'b0001, 1'b1, 8'h10, 2'd0};
    tbl[7] = '{4'b0000, 1'b0, 4'b0000, 1'b1, 8'h10, 2'd0};

    reset_n   = 1'b0;
    req_valid = '0;
    req_bits  = '0;
    mem_ready = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", 32'(mem_valid), 32'd0);
    chk("rst_bits", 32'(mem_bits), 32'h00);
    chk("rst_idx", 32'(mem_idx), 32'd0);
    reset_n = 1'b1;
    #1;
    chk("rst_ready", 32'(req_ready), 32'd0);

    for (int i = 0; i < 8; i++) begin
      run_cycle(tbl[i].v, PAY, tbl[i].mr, r);
      chk("tbl_ready", 32'(r), 32'(tbl[i].rdy));
      chk("tbl_valid", 32'(mem_valid), 32'(tbl[i].mv));
      chk("tbl_bits", 32'(mem_bits), 32'(tbl[i].mb));
      chk("tbl_idx", 32'(mem_idx), 32'(tbl[i].mi));
    end

    // Backpressure: register holds 0x10 / idx 0 from the last table row.
    for (int k = 0; k < 5; k++) begin
      b = $urandom;
      run_cycle(4'b1111, b, 1'b0, r);
      chk("bp_ready", 32'(r), 32'd0);
      chk("bp_valid", 32'(mem_valid), 32'd1);
      chk("bp_bits", 32'(mem_bits), 32'h10);
      chk("bp_idx", 32'(mem_idx), 32'd0);
    end
    run_cycle(4'b0100, 32'h00550000, 1'b1, r);
    chk("bp_rel_ready", 32'(r), 32'b0100);
    chk("bp_rel_valid", 32'(mem_valid), 32'd1);
    chk("bp_rel_bits", 32'(mem_bits), 32'h55);
    chk("bp_rel_idx", 32'(mem_idx), 32'd2);

    for (int k = 0; k < 8; k++) begin
      b = '0;
      b[2*W +: W] = 8'(8'h20 + k);
      run_cycle(4'b0100, b, 1'b1, r);
      chk("tput_valid", 32'(mem_valid), 32'd1);
      chk("tput_bits", 32'(mem_bits), 32'(8'h20 + k));
      chk("tput_idx", 32'(mem_idx), 32'd2);
    end

    for (int k = 0; k < 400; k++) begin
      run_cycle(4'($urandom_range(0, 15)), $urandom, ($urandom_range(0, 3) != 0), r);
    end

    // Mid-transfer reset with the memory side stalled.
    run_cycle(4'b0010, 32'h0000AA00, 1'b0, r);
    run_cycle(4'b0000, 32'h0, 1'b0, r);
    chk("pre_rst_valid", 32'(mem_valid), 32'd1);
    #1;
    reset_n = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(mem_valid), 32'd0);
    chk("mid_rst_bits", 32'(mem_bits), 32'h00);
    chk("mid_rst_idx", 32'(mem_idx), 32'd0);
    model_reset();
    repeat (2) @(posedge clk);
    #2;
    reset_n = 1'b1;

    for (int k = 0; k < 6; k++) begin
      run_cycle(4'b1111, PAY, 1'b1, r);
`ifdef VEC_ARB_RR_EN
      exp_i = k % 4;
`else
      exp_i = 3;
`endif
      chk("post_rst_idx", 32'(mem_idx), 32'(exp_i));
      chk("post_rst_bits", 32'(mem_bits), 32'(8'h10 + exp_i));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
